pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the pipelined RV32I core. It is the generic successor to the fixed per-stage latches: IF/ID, ID/EX, EX/MEM and MEM/WB are all built from this block.
- Carries an opaque payload bus (pc, operands, instr, rd) and a control bus (wren, mem_ren/wren, wb_sel, ...) through DEPTH register slices.
- Adds hazard-unit stall/flush handling, bubble sanitisation of the control bus, and saturating performance counters for the stall and kill events.

---
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the RV32I core.
// DEPTH slices with stall/flush, bubble sanitising and event counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_kill_cnt
);

    localparam int SUM_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic                         busy_q, busy_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]             kill_cnt_q, kill_cnt_d;
    logic [2:0]                   kill_pop;
    logic [SUM_W-1:0]             kill_sum;

    // Slice next-state: flush beats stall beats advance.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (i_flush) begin
            vld_d  = '0;
            data_d = '0;
            ctrl_d = '0;
        end else if (!i_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
                ctrl_d[k] = ctrl_q[k-1];
            end
            // Invalid slots still carry payload (pc) but never control.
            vld_d[0]  = i_vld;
            data_d[0] = i_data;
            ctrl_d[0] = i_vld ? i_ctrl : '0;
        end
        busy_d = |vld_d;
    end

    // Saturating stall and kill counters.
    always_comb begin
        kill_pop = '0;
        for (int k = 0; k < DEPTH; k++) begin
            kill_pop = kill_pop + 3'(vld_q[k]);
        end
        kill_sum    = SUM_W'(kill_cnt_q) + SUM_W'(kill_pop);
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (i_flush) begin
            if (kill_sum > SUM_W'(CNT_MAX)) begin
                kill_cnt_d = CNT_MAX;
            end else begin
                kill_cnt_d = kill_sum[CNT_W-1:0];
            end
        end else if (i_stall) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q       <= '0;
            data_q      <= '0;
            ctrl_q      <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            vld_q       <= vld_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign o_vld       = vld_q[DEPTH-1];
    assign o_data      = data_q[DEPTH-1];
    assign o_ctrl      = ctrl_q[DEPTH-1];
    assign o_busy      = busy_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg.
// Four instances (DEPTH 1/2/3 and a 4-bit counter variant) share inputs.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, vld;
    logic [31:0] data;
    logic [7:0]  ctrl;

    logic        v1, v2, v3, v4;
    logic [31:0] dt1, dt2, dt3, dt4;
    logic [7:0]  c1, c2, c3, c4;
    logic        b1, b2, b3, b4;
    logic [15:0] s1, s2, s3, k1, k2, k3;
    logic [3:0]  s4, k4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1)) d1 (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_vld(vld), .i_data(data), .i_ctrl(ctrl),
        .o_vld(v1), .o_data(dt1), .o_ctrl(c1), .o_busy(b1),
        .o_stall_cnt(s1), .o_kill_cnt(k1)
    );

    pipe_stage_reg #(.DEPTH(2)) d2 (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_vld(vld), .i_data(data), .i_ctrl(ctrl),
        .o_vld(v2), .o_data(dt2), .o_ctrl(c2), .o_busy(b2),
        .o_stall_cnt(s2), .o_kill_cnt(k2)
    );

    pipe_stage_reg #(.DEPTH(3)) d3 (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_vld(vld), .i_data(data), .i_ctrl(ctrl),
        .o_vld(v3), .o_data(dt3), .o_ctrl(c3), .o_busy(b3),
        .o_stall_cnt(s3), .o_kill_cnt(k3)
    );

    pipe_stage_reg #(.DEPTH(2), .CNT_W(4)) d4 (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_vld(vld), .i_data(data), .i_ctrl(ctrl),
        .o_vld(v4), .o_data(dt4), .o_ctrl(c4), .o_busy(b4),
        .o_stall_cnt(s4), .o_kill_cnt(k4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [7:0] c);
        vld  = v;
        data = d;
        ctrl = c;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0);

        // Reset for two cycles
        tick();
        tick();
        chk("rst_vld", 32'(v2), 32'h0);
        chk("rst_data", dt2, 32'h0);
        chk("rst_ctrl", 32'(c2), 32'h0);
        chk("rst_busy", 32'(b2), 32'h0);
        chk("rst_stall", 32'(s2), 32'h0);
        chk("rst_kill", 32'(k2), 32'h0);

        // Pass-through, DEPTH=2: latency 2
        rst = 1'b0;
        drive(1'b1, 32'h1000, 8'h15);
        tick();
        drive(1'b0, 32'h0, 8'h0);
        chk("pt_c1_vld", 32'(v2), 32'h0);
        chk("pt_c1_data", dt2, 32'h0);
        chk("pt_c1_ctrl", 32'(c2), 32'h0);
        chk("pt_c1_busy", 32'(b2), 32'h1);
        tick();
        chk("pt_c2_vld", 32'(v2), 32'h1);
        chk("pt_c2_data", dt2, 32'h1000);
        chk("pt_c2_ctrl", 32'(c2), 32'h15);

        // Bubble sanitisation, DEPTH=1
        drive(1'b0, 32'hABCD, 8'hFF);
        tick();
        chk("bub_vld", 32'(v1), 32'h0);
        chk("bub_ctrl", 32'(c1), 32'h0);
        chk("bub_data", dt1, 32'hABCD);
        chk("bub_busy", 32'(b1), 32'h0);

        // Clean counters, then stream 1,2,3 into DEPTH=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h1, 8'h5A);
        tick();
        drive(1'b1, 32'h2, 8'h5A);
        tick();
        drive(1'b1, 32'h3, 8'h5A);
        tick();
        chk("st_pre_data", dt2, 32'h2);
        stall = 1'b1;
        drive(1'b1, 32'h99, 8'h77);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("st_hold_data", dt2, 32'h2);
            chk("st_hold_vld", 32'(v2), 32'h1);
            chk("st_hold_ctrl", 32'(c2), 32'h5A);
            chk("st_cnt", 32'(s2), 32'(i));
        end
        stall = 1'b0;
        tick();
        drive(1'b0, 32'h0, 8'h0);
        chk("st_rel1_data", dt2, 32'h3);
        chk("st_rel_cnt", 32'(s2), 32'h3);
        tick();
        chk("st_rel2_data", dt2, 32'h99);
        chk("st_rel2_ctrl", 32'(c2), 32'h77);

        // Fill DEPTH=3, then flush+stall together
        drive(1'b1, 32'hA1, 8'h11);
        tick();
        drive(1'b1, 32'hA2, 8'h22);
        tick();
        drive(1'b1, 32'hA3, 8'h33);
        tick();
        chk("fl_pre_data", dt3, 32'hA1);
        chk("fl_pre_busy", 32'(b3), 32'h1);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        chk("fl_busy", 32'(b3), 32'h0);
        chk("fl_vld", 32'(v3), 32'h0);
        chk("fl_ctrl", 32'(c3), 32'h0);
        chk("fl_data", dt3, 32'h0);
        chk("fl_kill3", 32'(k3), 32'h3);
        chk("fl_stall3", 32'(s3), 32'h3);
        chk("fl_kill2", 32'(k2), 32'h2);
        chk("fl_kill1", 32'(k1), 32'h1);
        // Flush with nothing valid leaves the count alone
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty_kill", 32'(k3), 32'h3);

        // Saturation with CNT_W=4, counter starts at 3
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat_cnt", 32'(s4), (3 + i > 15) ? 32'hF : 32'(3 + i));
        end
        stall = 1'b0;
        chk("sat_d2_cnt", 32'(s2), 32'd23);

        // Reset mid-stream with flush: no kills counted
        drive(1'b1, 32'hB1, 8'h44);
        tick();
        drive(1'b1, 32'hB2, 8'h55);
        tick();
        chk("mr_pre_busy", 32'(b2), 32'h1);
        chk("mr_pre_data", dt2, 32'hB1);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        chk("mr_vld", 32'(v2), 32'h0);
        chk("mr_data", dt2, 32'h0);
        chk("mr_ctrl", 32'(c2), 32'h0);
        chk("mr_busy", 32'(b2), 32'h0);
        chk("mr_kill", 32'(k2), 32'h0);
        chk("mr_stall", 32'(s2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
